mem_dp: RTL and testbench
=========================

// Module: mem_dp
// PURPOSE
// - Parametrised simple-dual-port synchronous RAM: one write port, one read port, both usable every cycle.
// - Adds byte-enable writes, a configurable read pipeline with a valid strobe, and a defined collision policy.
// - Adds a self-clearing initialisation sequence after reset.
// - Serves as the general on-chip storage block (register files, scratch buffers, FIFOs built on top).
// PARAMETERS
// - DATA    8  data width in bits; must be a multiple of 8
// - ADDR    8  address width; depth = 2**ADDR words
// - LAT     1  read latency in cycles, legal 1..3
// - BYPASS  1  1 = write-first on same-address collision, 0 = read-first
// PORTS
// - clk    in   1         single clock; all logic on posedge clk
// - rst    in   1         one clock; reset is asynchronous and active-high
// - we     in   1         write request
// - waddr  in   ADDR      write address
// - wdata  in   DATA      write data
// - wbe    in   DATA/8    byte enables; bit i covers wdata[8i+7:8i]
// - re     in   1         read request
// - raddr  in   ADDR      read address
// - rdata  out  DATA      read data; holds last value when rvalid=0 (never Z)
// - rvalid out  1         rdata valid this cycle
// - busy   out  1         high while the clear sequence runs; requests ignored
// BEHAVIOUR
// - Reset values: rdata=0, rvalid=0, busy=1, FSM=CLEAR, clear counter=0, read pipeline valid bits=0.
// - FSM CLEAR: each cycle write 0 to mem[cnt], cnt++.
//   - At cnt==2**ADDR-1, write it, then go to READY next cycle.
//   - busy drops in the same cycle the state becomes READY.
//   - The clear takes exactly 2**ADDR cycles after rst deasserts.
// - FSM READY: terminal state; only rst returns the FSM to CLEAR.
// - Any rst assertion mid-operation or mid-clear:
//   - aborts immediately and restarts the clear from address 0;
//   - all in-flight reads are dropped (rvalid=0).
// - Write (READY, we=1): on the clock edge, mem[waddr] byte i <= wdata byte i where wbe[i]=1; others keep their value.
//   - wbe=0 is a legal no-op.
// - Read (READY, re=1): samples raddr at edge N; rdata/rvalid present the word after edge N+LAT-1.
//   - Pipeline is fully throughput-1: back-to-back reads give back-to-back rvalid.
// - Collision (re & we & raddr==waddr, same edge):
//   - BYPASS=1: returned word = old word with enabled bytes replaced by wdata.
//   - BYPASS=0: returned word = old word.
//   - Memory updates identically in both modes.
// - A read issued the cycle after a write to the same address always sees the new data.
// - Requests during busy are dropped: no memory change, no rvalid.
// - Addresses wrap naturally (full ADDR-bit range); there is no out-of-range case.
// STRUCTURE
// - Shared package mem_pkg:
//   - typedef enum logic {CLEAR, READY} mem_state_e;
//   - localparam MAX_LAT = 3.
// - Sub-module mem_rd_pipe #(DATA, LAT):
//   - LAT-stage data+valid shift pipeline;
//   - valid bits async-reset to 0; data bits enable-gated to hold.
// - Top holds the array (no reset on the array itself), FSM, clear counter, collision merge mux.
// TESTING (DATA=16, ADDR=4, LAT=2 unless noted)
// - Reset/clear:
//   - pulse rst, then read all 16 addresses after busy=0;
//   - busy is high exactly 16 cycles and every read returns 16'h0000.
// - Byte enables: write 16'hA5C3 wbe=2'b11 to addr 3, then 16'hFF00 wbe=2'b01 to addr 3, read addr 3 -> 16'hA500.
// - Latency/throughput:
//   - reads of addr 0..3 on 4 consecutive cycles (preloaded with 1,2,3,4);
//   - rvalid high 2 cycles after the first read, for 4 cycles, with data 1,2,3,4 in order.
// - Collision:
//   - addr 5 holds 16'h1234; same-cycle write 16'hABCD wbe=2'b10 and read of addr 5;
//   - BYPASS=1 -> 16'hAB34, BYPASS=0 -> 16'h1234;
//   - a following read returns 16'hAB34 in both modes.
// - Reset mid-operation:
//   - assert rst while 2 reads are in flight;
//   - rvalid drops asynchronously and stays 0, busy=1, the clear restarts;
//   - the written address reads 0 afterwards.
// - Busy drop: we=1/re=1 during CLEAR -> no rvalid, and memory still reads 0 after the clear.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and limits for the simple-dual-port RAM block.
package mem_pkg;
   typedef enum logic {CLEAR, READY} mem_state_e;
   localparam int MAX_LAT = 3;
endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline: LAT stages of data+valid, data only advances with a valid beat.
module mem_rd_pipe #(
   parameter int DATA = 8,
   parameter int LAT  = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            vld_i,
   input  logic [DATA-1:0] dat_i,
   output logic            vld_o,
   output logic [DATA-1:0] dat_o
);
   logic [LAT-1:0]           vld_q, vld_d;
   logic [LAT-1:0][DATA-1:0] dat_q, dat_d;

   always_comb begin
      vld_d    = '0;
      dat_d    = '0;
      vld_d[0] = vld_i;
      dat_d[0] = dat_i;
      for (int k = 1; k < LAT; k++) begin
         vld_d[k] = vld_q[k-1];
         dat_d[k] = dat_q[k-1];
      end
   end

   // Data registers hold when no valid beat arrives, so rdata keeps its last value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < LAT; k++)
            if (vld_d[k]) dat_q[k] <= dat_d[k];
      end
   end

   assign vld_o = vld_q[LAT-1];
   assign dat_o = dat_q[LAT-1];
endmodule

// File: rtl/mem_dp.sv
// Simple-dual-port RAM with byte enables, pipelined read, collision policy and
// a self-clearing sequence after reset.
module mem_dp
   import mem_pkg::*;
#(
   parameter int DATA   = 8,
   parameter int ADDR   = 8,
   parameter int LAT    = 1,
   parameter int BYPASS = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR-1:0]   waddr_i,
   input  logic [DATA-1:0]   wdata_i,
   input  logic [DATA/8-1:0] wbe_i,
   input  logic              re_i,
   input  logic [ADDR-1:0]   raddr_i,
   output logic [DATA-1:0]   rdata_o,
   output logic              rvalid_o,
   output logic              busy_o
);
   localparam int NB    = DATA / 8;
   localparam int DEPTH = 1 << ADDR;
   localparam int PLAT  = (LAT < 1) ? 1 : ((LAT > MAX_LAT) ? MAX_LAT : LAT);

   mem_state_e      state_q;
   logic [ADDR-1:0] cnt_q;
   logic            busy_q;
   logic [DATA-1:0] mem_q [DEPTH];

   logic            wr_en, rd_en, hit;
   logic [DATA-1:0] rd_word;

   assign wr_en = we_i & ~busy_q;
   assign rd_en = re_i & ~busy_q;
   assign hit   = wr_en & rd_en & (waddr_i == raddr_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // The array itself is never reset; the clear sequence zeroes it one word per cycle.
   always_ff @(posedge clk_i) begin
      if (busy_q)
         mem_q[cnt_q] <= '0;
      else if (wr_en)
         for (int i = 0; i < NB; i++)
            if (wbe_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
   end

   always_comb begin
      rd_word = mem_q[raddr_i];
      if (BYPASS != 0 && hit)
         for (int i = 0; i < NB; i++)
            if (wbe_i[i]) rd_word[8*i +: 8] = wdata_i[8*i +: 8];
   end

   mem_rd_pipe #(.DATA(DATA), .LAT(PLAT)) u_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .vld_i (rd_en),
      .dat_i (rd_word),
      .vld_o (rvalid_o),
      .dat_o (rdata_o)
   );

   assign busy_o = busy_q;
endmodule

// File: tb/tb_mem_dp.sv
// Randomized bench for mem_dp: write-first and read-first instances driven in
// lockstep against a word-level reference memory and a due-cycle read queue.
module tb_mem_dp;
   localparam int DW = 16, AW = 4, L = 2, D = 16;

   logic clk = 1'b0;
   logic rst;
   logic we, re;
   logic [AW-1:0] waddr, raddr;
   logic [DW-1:0] wdata;
   logic [1:0]    wbe;
   logic [DW-1:0] rdata1, rdata0;
   logic          rvalid1, rvalid0, busy1, busy0;

   always #5 clk = ~clk;

   mem_dp #(.DATA(DW), .ADDR(AW), .LAT(L), .BYPASS(1)) u_wf (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata1), .rvalid_o(rvalid1), .busy_o(busy1));
   mem_dp #(.DATA(DW), .ADDR(AW), .LAT(L), .BYPASS(0)) u_rf (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
      .re_i(re), .raddr_i(raddr), .rdata_o(rdata0), .rvalid_o(rvalid0), .busy_o(busy0));

   typedef struct { int due; logic [DW-1:0] w1; logic [DW-1:0] w0; } rd_t;
   rd_t           q[$];
   logic [DW-1:0] ref_mem [D];
   logic [DW-1:0] last1, last0;
   int            clr_left, ecnt;
   int            n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mrg(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                         input logic [1:0] be);
      mrg = o;
      if (be[0]) mrg[7:0]  = d[7:0];
      if (be[1]) mrg[15:8] = d[15:8];
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < D; i++) ref_mem[i] = '0;
      last1 = '0;
      last0 = '0;
      clr_left = D;
   endtask

   // One clock: drive at negedge, predict the edge, check #1 after it, return at next negedge.
   task automatic cyc(input bit w, input bit r, input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                      input logic [DW-1:0] wd, input logic [1:0] be);
      logic [DW-1:0] old;
      bit            ev;
      we = w; re = r; waddr = wa; raddr = ra; wdata = wd; wbe = be;
      ecnt++;
      if (clr_left > 0) clr_left--;
      else begin
         if (r) begin
            old = ref_mem[ra];
            q.push_back('{ecnt + L - 1, (w && wa == ra) ? mrg(old, wd, be) : old, old});
         end
         if (w) ref_mem[wa] = mrg(ref_mem[wa], wd, be);
      end
      @(posedge clk);
      #1;
      chk("busy_wf", busy1, clr_left > 0);
      chk("busy_rf", busy0, clr_left > 0);
      ev = (q.size() > 0) && (q[0].due == ecnt);
      chk("rvalid_wf", rvalid1, ev);
      chk("rvalid_rf", rvalid0, ev);
      if (ev) begin
         last1 = q[0].w1;
         last0 = q[0].w0;
         void'(q.pop_front());
      end
      chk("rdata_wf", rdata1, last1);
      chk("rdata_rf", rdata0, last0);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, '0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      cyc(0, 1, '0, a, '0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      cyc(1, 0, a, '0, d, be);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; we = 0; re = 0; waddr = '0; raddr = '0; wdata = '0; wbe = '0; ecnt = 0;
      model_reset();
      #1;
      chk("rst_busy", busy1, 1'b1);
      chk("rst_rvalid", rvalid1, 1'b0);
      chk("rst_rdata", rdata1, 16'h0000);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Requests during the clear are dropped; busy must last exactly D cycles.
      for (int i = 0; i < D; i++)
         cyc(1, 1, AW'($urandom_range(0, D-1)), AW'($urandom_range(0, D-1)), 16'hFFFF, 2'b11);
      for (int i = 0; i < D; i++) rd(AW'(i));
      idle(L);

      wr(3, 16'hA5C3, 2'b11);
      wr(3, 16'hFF00, 2'b01);
      rd(3);
      idle(L);
      chk("byte_en", rdata1, 16'hA500);

      for (int i = 0; i < 4; i++) wr(AW'(i), DW'(i + 1), 2'b11);
      for (int i = 0; i < 4; i++) rd(AW'(i));
      idle(L);

      wr(5, 16'h1234, 2'b11);
      cyc(1, 1, 5, 5, 16'hABCD, 2'b10);
      idle(1);
      chk("coll_wf", rdata1, 16'hAB34);
      chk("coll_rf", rdata0, 16'h1234);
      rd(5);
      idle(L);
      chk("coll_after_wf", rdata1, 16'hAB34);
      chk("coll_after_rf", rdata0, 16'hAB34);

      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
             DW'($urandom), 2'($urandom_range(0, 3)));
      idle(L);

      // Reset while one result is visible and another is in flight.
      wr(7, 16'hBEEF, 2'b11);
      rd(7);
      rd(7);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_rvalid_wf", rvalid1, 1'b0);
      chk("midrst_rvalid_rf", rvalid0, 1'b0);
      chk("midrst_busy", busy1, 1'b1);
      model_reset();
      @(posedge clk);
      #1;
      chk("midrst_rvalid_hold", rvalid1, 1'b0);
      chk("midrst_rdata", rdata1, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      idle(D);
      rd(7);
      idle(L);
      chk("midrst_cleared", rdata1, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
